// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_responder_pkg;
  localparam int WORD_W = 32;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents never reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: IDLE/RESP handshake FSM, optional wait
// states when DMEM_WAIT_STATES_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              SW_in,
  input  logic [WORD_W-1:0] daddrbus,
  input  logic [WORD_W-1:0] databus_in,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              addr_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e          state_q, state_d;
  logic            is_sw_q, err_q;
  logic            accept, in_range, rd_en;
  logic [AW-1:0]   idx, raddr;
  logic [WORD_W-1:0] rdata;
  logic            unused_bits;

  assign idx       = daddrbus[AW+1:2];
  assign in_range  = (daddrbus[WORD_W-1:AW+2] == '0);
  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef DMEM_WAIT_STATES_EN
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     idx_q;

  assign unused_bits = ^daddrbus[1:0];
`else
  assign unused_bits = ^{daddrbus[1:0], (WAIT_CYCLES != 0)};
`endif

  always_comb begin
    state_d = state_q;
`ifdef DMEM_WAIT_STATES_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
`ifdef DMEM_WAIT_STATES_EN
        if (WAIT_CYCLES == 0) state_d = ST_RESP;
        else begin
          state_d = ST_WAIT;
          cnt_d   = WCNT_W'(WAIT_CYCLES - 1);
        end
`else
        state_d = ST_RESP;
`endif
      end
`ifdef DMEM_WAIT_STATES_EN
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
               else cnt_d = cnt_q - 1'b1;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The read fires on the edge entering RESP, from live inputs when coming
  // straight from IDLE, otherwise from the address captured at acceptance.
`ifdef DMEM_WAIT_STATES_EN
  assign raddr = (state_q == ST_IDLE) ? idx : idx_q;
  assign rd_en = (state_d == ST_RESP) &&
                 ((state_q == ST_IDLE) ? (!SW_in && in_range) :
                  (state_q == ST_WAIT) ? (!is_sw_q && !err_q) : 1'b0);
`else
  assign raddr = idx;
  assign rd_en = accept && !SW_in && in_range;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      is_sw_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q   <= cnt_d;
      if (accept) idx_q <= idx;
`endif
      if (accept) begin
        is_sw_q <= SW_in;
        err_q   <= !in_range;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (accept && SW_in && in_range),
    .waddr_i (idx),
    .wdata_i (databus_in),
    .re_i    (rd_en),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign addr_err  = rsp_valid && err_q;
  assign rsp_data  = (rsp_valid && !is_sw_q && !err_q) ? rdata : '0;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the number of 32-bit words in the memory (power of two, 2..256).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, the number of extra wait-state cycles per access (0..15), used only when the macro in REQ-022 is defined.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1, a MEM-stage access request.
REQ-006 The block SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 The block SHALL have port SW_in, input, 1, 1 = store word, 0 = load word.
REQ-008 The block SHALL have port daddrbus, input, 32, the byte address of the access.
REQ-009 The block SHALL have port databus_in, input, 32, the store data.
REQ-010 The block SHALL have port rsp_valid, output, 1, a one-cycle response pulse.
REQ-011 The block SHALL have port rsp_data, output, 32, the load data; it is 0 for stores.
REQ-012 The block SHALL have port addr_err, output, 1, asserted with rsp_valid when the access was out of range.

Function
REQ-013 Memory SHALL be DEPTH x 32, word-indexed by daddrbus[log2(DEPTH)+1:2]; daddrbus[1:0] ignored.
REQ-014 An address SHALL be out of range when any daddrbus bit above log2(DEPTH)+1 is nonzero; out-of-range store is discarded, out-of-range load returns 0, and addr_err=1 in the response cycle.
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; SW_in, daddrbus and databus_in are captured on that edge.
REQ-017 An in-range store SHALL write memory on the acceptance edge.
REQ-018 Transitions: IDLE->RESP on accept (macro off, or WAIT_CYCLES=0); IDLE->WAIT on accept (macro on, WAIT_CYCLES>0); WAIT->RESP when the wait counter reaches 0; RESP->IDLE always.
REQ-019 Latency SHALL be: rsp_valid asserted exactly 1 cycle after acceptance (macro off), or 1+WAIT_CYCLES cycles after acceptance (macro on); rsp_valid stays high for exactly 1 cycle.
REQ-020 Load data SHALL be read on the edge entering RESP and held on rsp_data only while rsp_valid=1; otherwise rsp_data=0 and addr_err=0.
REQ-021 Throughput: at most one request per 2 cycles (macro off); req_valid while req_ready=0 is ignored, and the requester holds it until accepted.

Configuration
REQ-022 Macro DMEM_WAIT_STATES_EN, when defined, SHALL include the 4-bit wait counter and WAIT state; when undefined, WAIT and the counter are absent, WAIT_CYCLES is ignored, and latency is fixed at 1.

Reset
REQ-023 On an edge with rst_n=0, the block SHALL set state=IDLE, wait counter=0, rsp_valid=0, rsp_data=0 and addr_err=0; req_ready is 1 in the first cycle after reset.
REQ-024 Reset during WAIT or RESP SHALL abort the access with no response pulse, and any store already committed on acceptance is retained.
REQ-025 Memory contents SHALL NOT be reset.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, WAIT, RESP), the word width constant 32, and the wait-counter width constant 4.
REQ-027 The storage array SHALL be a sub-module dmem_array (sync write, registered read); the FSM and counter live in dmem_responder.

Verification
REQ-028 Reset then store 0xDEADBEEF to 0x8, then load 0x8 -> the load's rsp_valid pulse carries rsp_data=0xDEADBEEF and addr_err=0.
REQ-029 Macro off, load accepted at cycle N -> rsp_valid=1 at N+1 only; macro on with WAIT_CYCLES=2 -> rsp_valid=1 at N+3 only, and req_ready=0 from N+1 through N+3.
REQ-030 Load 0x40 with DEPTH=16 -> rsp_data=0 and addr_err=1; store 0x40 with 0x1234 -> memory unchanged.
REQ-031 req_valid held high continuously over 4 loads, macro off -> accepts on alternate cycles, with exactly 4 rsp_valid pulses.
REQ-032 rst_n=0 during WAIT (macro on) -> no rsp_valid, req_ready=1 in the first cycle after reset, and a store accepted before reset is still readable.
